// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and engine state types for the memory-backed responder.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_1B = 3'd0;
    localparam logic [2:0] SIZE_2B = 3'd1;
    localparam logic [2:0] SIZE_4B = 3'd2;
    localparam logic [2:0] SIZE_8B = 3'd3;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Per-beat address step for FIXED/INCR/WRAP bursts plus the array-window range check.
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int               ADDR_W    = 32,
    parameter int               MEM_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              in_range
);

    // One extra bit so the end of the window cannot overflow the address width
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(MEM_WORDS) << 3;

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;

    assign offset    = addr - BASE_ADDR;
    assign in_range  = (addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    assign step      = ADDR_W'(1) << size;
    assign wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);

    always_comb begin
        next_addr = addr + step;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default:     next_addr = addr + step;
        endcase
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 responder backed by an on-chip word array; independent read and write engines,
// each with a single outstanding burst.
module axi_mem_slave
    import axi_pkg::*;
#(
    parameter int               ADDR_W    = 32,
    parameter int               DATA_W    = 64,
    parameter int               ID_W      = 4,
    parameter int               MEM_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int               RD_LAT    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                axi_aw_valid_i,
    output logic                axi_aw_ready_o,
    input  logic [ADDR_W-1:0]   axi_aw_addr_i,
    input  logic [ID_W-1:0]     axi_aw_id_i,
    input  logic [7:0]          axi_aw_len_i,
    input  logic [2:0]          axi_aw_size_i,
    input  logic [1:0]          axi_aw_burst_i,
    input  logic                axi_w_valid_i,
    output logic                axi_w_ready_o,
    input  logic [DATA_W-1:0]   axi_w_data_i,
    input  logic [DATA_W/8-1:0] axi_w_strb_i,
    input  logic                axi_w_last_i,
    output logic                axi_b_valid_o,
    input  logic                axi_b_ready_i,
    output logic [1:0]          axi_b_resp_o,
    output logic [ID_W-1:0]     axi_b_id_o,
    input  logic                axi_ar_valid_i,
    output logic                axi_ar_ready_o,
    input  logic [ADDR_W-1:0]   axi_ar_addr_i,
    input  logic [ID_W-1:0]     axi_ar_id_i,
    input  logic [7:0]          axi_ar_len_i,
    input  logic [2:0]          axi_ar_size_i,
    input  logic [1:0]          axi_ar_burst_i,
    output logic                axi_r_valid_o,
    input  logic                axi_r_ready_i,
    output logic [DATA_W-1:0]   axi_r_data_o,
    output logic [1:0]          axi_r_resp_o,
    output logic                axi_r_last_o,
    output logic [ID_W-1:0]     axi_r_id_o
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 3);
    endfunction

    rd_state_e         r_state, r_state_nxt;
    logic [ADDR_W-1:0] r_addr, r_next_addr;
    logic [ID_W-1:0]   r_id;
    logic [7:0]        r_len, r_beat, r_lat;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [DATA_W-1:0] r_word, r_fetch;
    logic              r_in_range, r_beat_err;

    axi_burst_addr #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)) u_rd_addr (
        .addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst),
        .next_addr(r_next_addr), .in_range(r_in_range)
    );

    // The beat word is registered one step ahead so R payload cannot move during a stall
    assign r_fetch    = mem[word_idx((r_state == R_DATA) ? r_next_addr : r_addr)];
    assign r_beat_err = !r_in_range || (r_size > SIZE_8B) || (r_burst == 2'b11);

    always_comb begin
        r_state_nxt    = r_state;
        axi_ar_ready_o = 1'b0;
        axi_r_valid_o  = 1'b0;
        case (r_state)
            R_IDLE: begin
                axi_ar_ready_o = rst;
                if (rst && axi_ar_valid_i) r_state_nxt = R_WAIT;
            end
            R_WAIT: if (r_lat == 8'd0) r_state_nxt = R_DATA;
            R_DATA: begin
                axi_r_valid_o = 1'b1;
                if (axi_r_ready_i && (r_beat == r_len)) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= R_IDLE;
        else      r_state <= r_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr  <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_lat   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_word  <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (axi_ar_valid_i) begin
                    r_addr  <= axi_ar_addr_i;
                    r_id    <= axi_ar_id_i;
                    r_len   <= axi_ar_len_i;
                    r_size  <= axi_ar_size_i;
                    r_burst <= axi_ar_burst_i;
                    r_beat  <= '0;
                    r_lat   <= 8'(RD_LAT - 1);
                end
                R_WAIT: begin
                    if (r_lat != 8'd0) r_lat  <= r_lat - 8'd1;
                    else               r_word <= r_fetch;
                end
                R_DATA: if (axi_r_ready_i) begin
                    r_beat <= r_beat + 8'd1;
                    r_addr <= r_next_addr;
                    r_word <= r_fetch;
                end
                default: ;
            endcase
        end
    end

    assign axi_r_data_o = (axi_r_valid_o && !r_beat_err) ? r_word : '0;
    assign axi_r_resp_o = (axi_r_valid_o && r_beat_err) ? RESP_SLVERR : RESP_OKAY;
    assign axi_r_last_o = axi_r_valid_o && (r_beat == r_len);
    assign axi_r_id_o   = axi_r_valid_o ? r_id : '0;

    wr_state_e         w_state, w_state_nxt;
    logic [ADDR_W-1:0] w_addr, w_next_addr;
    logic [ID_W-1:0]   w_id;
    logic [7:0]        w_len, w_beat;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic              w_err, w_in_range, w_beat_err;

    axi_burst_addr #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)) u_wr_addr (
        .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst),
        .next_addr(w_next_addr), .in_range(w_in_range)
    );

    assign w_beat_err = !w_in_range || (w_size > SIZE_8B) || (w_burst == 2'b11);

    always_comb begin
        w_state_nxt    = w_state;
        axi_aw_ready_o = 1'b0;
        axi_w_ready_o  = 1'b0;
        axi_b_valid_o  = 1'b0;
        case (w_state)
            W_IDLE: begin
                axi_aw_ready_o = rst;
                if (rst && axi_aw_valid_i) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                axi_w_ready_o = 1'b1;
                if (axi_w_valid_i && (w_beat == w_len)) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                axi_b_valid_o = 1'b1;
                if (axi_b_ready_i) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) w_state <= W_IDLE;
        else      w_state <= w_state_nxt;
    end

    // Any beat error or a misplaced WLAST poisons the whole burst's B response
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_addr  <= '0;
            w_id    <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (axi_aw_valid_i) begin
                    w_addr  <= axi_aw_addr_i;
                    w_id    <= axi_aw_id_i;
                    w_len   <= axi_aw_len_i;
                    w_size  <= axi_aw_size_i;
                    w_burst <= axi_aw_burst_i;
                    w_beat  <= '0;
                    w_err   <= 1'b0;
                end
                W_DATA: if (axi_w_valid_i) begin
                    w_beat <= w_beat + 8'd1;
                    w_addr <= w_next_addr;
                    w_err  <= w_err | w_beat_err | (axi_w_last_i != (w_beat == w_len));
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && (w_state == W_DATA) && axi_w_valid_i && w_in_range && (w_size <= SIZE_8B)) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (axi_w_strb_i[i]) mem[word_idx(w_addr)][8*i +: 8] <= axi_w_data_i[8*i +: 8];
            end
        end
    end

    assign axi_b_resp_o = (axi_b_valid_o && w_err) ? RESP_SLVERR : RESP_OKAY;
    assign axi_b_id_o   = axi_b_valid_o ? w_id : '0;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomised and directed bench for axi_mem_slave against a byte-level array model.
module tb_axi_mem_slave;

    localparam int          MEM_WORDS = 4096;
    localparam int          RD_LAT    = 2;
    localparam int          LIMIT     = 200;
    localparam logic [31:0] BASE      = 32'h8000_0000;

    logic        clk, rst;
    logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic [31:0] aw_addr, ar_addr;
    logic [3:0]  aw_id, ar_id, b_id, r_id;
    logic [7:0]  aw_len, ar_len, w_strb;
    logic [2:0]  aw_size, ar_size;
    logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
    logic [63:0] w_data, r_data;
    logic        ar_valid, ar_ready, r_valid, r_ready, r_last;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [63:0] model [MEM_WORDS];
    logic [63:0] wData [256];
    logic [7:0]  wStrb [256];

    axi_mem_slave #(
        .ADDR_W(32), .DATA_W(64), .ID_W(4), .MEM_WORDS(MEM_WORDS),
        .BASE_ADDR(BASE), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .axi_aw_valid_i(aw_valid), .axi_aw_ready_o(aw_ready), .axi_aw_addr_i(aw_addr),
        .axi_aw_id_i(aw_id), .axi_aw_len_i(aw_len), .axi_aw_size_i(aw_size), .axi_aw_burst_i(aw_burst),
        .axi_w_valid_i(w_valid), .axi_w_ready_o(w_ready), .axi_w_data_i(w_data),
        .axi_w_strb_i(w_strb), .axi_w_last_i(w_last),
        .axi_b_valid_o(b_valid), .axi_b_ready_i(b_ready), .axi_b_resp_o(b_resp), .axi_b_id_o(b_id),
        .axi_ar_valid_i(ar_valid), .axi_ar_ready_o(ar_ready), .axi_ar_addr_i(ar_addr),
        .axi_ar_id_i(ar_id), .axi_ar_len_i(ar_len), .axi_ar_size_i(ar_size), .axi_ar_burst_i(ar_burst),
        .axi_r_valid_o(r_valid), .axi_r_ready_i(r_ready), .axi_r_data_o(r_data),
        .axi_r_resp_o(r_resp), .axi_r_last_o(r_last), .axi_r_id_o(r_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: run did not complete within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // k-th beat address straight from the burst rules: offset k*step, wrapped modulo the window
    function automatic logic [31:0] beatAddr(input logic [31:0] start, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst, input int k);
        longint step, s, win, lo;
        step = longint'(1) << size;
        s    = longint'(start);
        if (burst == 2'b00) return start;
        if (burst == 2'b10) begin
            win = (longint'(len) + 1) * step;
            lo  = s - (s % win);
            return 32'(lo + ((s - lo + k * step) % win));
        end
        return 32'(s + k * step);
    endfunction

    function automatic bit inRange(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(MEM_WORDS * 8));
    endfunction

    function automatic int wordIdx(input logic [31:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    task automatic writeBurst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [3:0] id, input int badLast, input int bStall);
        int          t;
        bit          err;
        logic [31:0] a;
        err = 1'b0;
        @(negedge clk);
        aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_id = id;
        t = 0;
        while (!aw_ready && t < LIMIT) begin @(negedge clk); t++; end
        if (t >= LIMIT) begin checkOutput("aw_timeout", 0, 1); aw_valid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        aw_valid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            w_valid = 1'b1; w_data = wData[k]; w_strb = wStrb[k];
            w_last  = (k == int'(len)) ^ (k == badLast);
            t = 0;
            while (!w_ready && t < LIMIT) begin @(negedge clk); t++; end
            if (t >= LIMIT) begin checkOutput("w_timeout", 0, 1); w_valid = 1'b0; return; end
            @(posedge clk);
            a = beatAddr(addr, len, size, burst, k);
            if (inRange(a)) begin
                for (int b = 0; b < 8; b++)
                    if (wStrb[k][b]) model[wordIdx(a)][8*b +: 8] = wData[k][8*b +: 8];
            end else begin
                err = 1'b1;
            end
            if (k == badLast) err = 1'b1;
            @(negedge clk);
        end
        w_valid = 1'b0; w_last = 1'b0;
        t = 0;
        while (!b_valid && t < LIMIT) begin @(negedge clk); t++; end
        if (t >= LIMIT) begin checkOutput("b_timeout", 0, 1); return; end
        for (int s = 0; s < bStall; s++) begin
            @(negedge clk);
            checkOutput("b_valid_held", b_valid, 1);
        end
        checkOutput("b_resp", b_resp, err ? 2 : 0);
        checkOutput("b_id", b_id, id);
        b_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_ready = 1'b0;
        checkOutput("b_valid_drop", b_valid, 0);
    endtask

    task automatic readBurst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [3:0] id,
                             input int stallBeat, input int stallCycles, input int abortBeat);
        int          t, lat;
        logic [31:0] a;
        logic [63:0] expData, snapData;
        logic        snapLast;
        @(negedge clk);
        ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_id = id;
        t = 0;
        while (!ar_ready && t < LIMIT) begin @(negedge clk); t++; end
        if (t >= LIMIT) begin checkOutput("ar_timeout", 0, 1); ar_valid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        ar_valid = 1'b0;
        lat = 0;
        while (!r_valid && lat < LIMIT) begin @(negedge clk); lat++; end
        checkOutput("r_latency", lat, RD_LAT);
        if (!r_valid) return;
        for (int k = 0; k <= int'(len); k++) begin
            t = 0;
            while (!r_valid && t < LIMIT) begin @(negedge clk); t++; end
            if (t >= LIMIT) begin checkOutput("r_timeout", 0, 1); return; end
            if (k == abortBeat) begin
                rst = 1'b0;
                @(posedge clk);
                @(negedge clk);
                checkOutput("rst_r_valid", r_valid, 0);
                checkOutput("rst_ar_ready", ar_ready, 0);
                rst = 1'b1;
                @(negedge clk);
                checkOutput("rst_release_ar_ready", ar_ready, 1);
                return;
            end
            a       = beatAddr(addr, len, size, burst, k);
            expData = inRange(a) ? model[wordIdx(a)] : 64'd0;
            if (k == stallBeat) begin
                snapData = r_data;
                snapLast = r_last;
                for (int s = 0; s < stallCycles; s++) begin
                    @(negedge clk);
                    checkOutput("r_stall_valid", r_valid, 1);
                    checkOutput("r_stall_data", r_data, snapData);
                    checkOutput("r_stall_last", r_last, snapLast);
                end
            end
            checkOutput("r_data", r_data, expData);
            checkOutput("r_resp", r_resp, inRange(a) ? 2'b00 : 2'b10);
            checkOutput("r_last", r_last, k == int'(len));
            checkOutput("r_id", r_id, id);
            r_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            r_ready = 1'b0;
        end
        checkOutput("r_valid_after_last", r_valid, 0);
        checkOutput("ar_ready_after_last", ar_ready, 1);
    endtask

    task automatic fillWriteData(input int beats, input bit randStrb);
        for (int k = 0; k < beats; k++) begin
            wData[k] = {$urandom, $urandom};
            wStrb[k] = randStrb ? 8'($urandom) : 8'hFF;
        end
    endtask

    // Random bursts of every type, narrow sizes, stalls, bad WLAST and spills past the array end
    task automatic applyStimulus(input int count);
        int          lens [4] = '{1, 3, 7, 15};
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] addr;
        int          word, stallBeat;
        for (int n = 0; n < count; n++) begin
            burst = 2'($urandom_range(0, 2));
            len   = (burst == 2'b10) ? 8'(lens[$urandom_range(0, 3)]) : 8'($urandom_range(0, 15));
            size  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 2)) : 3'd3;
            word  = ($urandom_range(0, 5) == 0) ? MEM_WORDS - 1 - int'($urandom_range(0, 2))
                                                : int'($urandom_range(0, MEM_WORDS - 1));
            addr  = BASE + 32'(word * 8) + (32'($urandom_range(0, 7)) & ~((32'd1 << size) - 32'd1));
            if ($urandom_range(0, 1) == 1) begin
                fillWriteData(int'(len) + 1, $urandom_range(0, 1) == 1);
                writeBurst(addr, len, size, burst, 4'($urandom),
                           ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len)) : -1,
                           int'($urandom_range(0, 3)));
            end else begin
                stallBeat = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len)) : -1;
                readBurst(addr, len, size, burst, 4'($urandom), stallBeat,
                          int'($urandom_range(1, 4)), -1);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        aw_valid = 1'b0; aw_addr = '0; aw_id = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
        w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; b_ready = 1'b0;
        ar_valid = 1'b0; ar_addr = '0; ar_id = '0; ar_len = '0; ar_size = '0; ar_burst = '0;
        r_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_aw_ready", aw_ready, 0);
        checkOutput("reset_ar_ready", ar_ready, 0);
        checkOutput("reset_w_ready", w_ready, 0);
        checkOutput("reset_b_valid", b_valid, 0);
        checkOutput("reset_r_valid", r_valid, 0);
        checkOutput("reset_r_data", r_data, 0);
        checkOutput("reset_r_last", r_last, 0);
        checkOutput("reset_b_resp", b_resp, 0);
        rst = 1'b1;

        $display("[TB] preloading array");
        for (int blk = 0; blk < MEM_WORDS / 256; blk++) begin
            fillWriteData(256, 1'b0);
            writeBurst(BASE + 32'(blk * 2048), 8'd255, 3'd3, 2'b01, 4'(blk), -1, 0);
        end

        $display("[TB] single beat read");
        wData[0] = 64'h1122_3344_5566_7788; wStrb[0] = 8'hFF;
        writeBurst(BASE, 8'd0, 3'd3, 2'b01, 4'h3, -1, 0);
        readBurst(BASE, 8'd0, 3'd3, 2'b01, 4'h5, -1, 0, -1);

        $display("[TB] INCR write with partial strobe");
        fillWriteData(4, 1'b0);
        wStrb[1] = 8'h0F;
        writeBurst(BASE + 32'h10, 8'd3, 3'd3, 2'b01, 4'h7, -1, 0);
        readBurst(BASE + 32'h10, 8'd3, 3'd3, 2'b01, 4'h8, -1, 0, -1);

        $display("[TB] WRAP read");
        readBurst(BASE + 32'h18, 8'd3, 3'd3, 2'b10, 4'h9, -1, 0, -1);

        $display("[TB] backpressure on R and B");
        readBurst(BASE + 32'h40, 8'd7, 3'd3, 2'b01, 4'hA, 3, 5, -1);
        fillWriteData(2, 1'b0);
        writeBurst(BASE + 32'h100, 8'd1, 3'd3, 2'b01, 4'hB, -1, 3);

        $display("[TB] out of range accesses");
        fillWriteData(1, 1'b0);
        writeBurst(32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 4'hC, -1, 0);
        readBurst(BASE + 32'((MEM_WORDS - 1) * 8), 8'd1, 3'd3, 2'b01, 4'hD, -1, 0, -1);

        $display("[TB] misplaced WLAST");
        fillWriteData(3, 1'b0);
        writeBurst(BASE + 32'h200, 8'd2, 3'd3, 2'b01, 4'h1, 1, 0);

        $display("[TB] concurrent read and write");
        fillWriteData(8, 1'b1);
        fork
            writeBurst(BASE + 32'h1000, 8'd7, 3'd3, 2'b01, 4'h2, -1, 1);
            readBurst(BASE + 32'h2000, 8'd7, 3'd3, 2'b01, 4'h4, 2, 2, -1);
        join

        $display("[TB] reset during read burst");
        readBurst(BASE + 32'h300, 8'd7, 3'd3, 2'b01, 4'hE, -1, 0, 3);
        readBurst(BASE + 32'h300, 8'd0, 3'd3, 2'b01, 4'hF, -1, 0, -1);

        $display("[TB] random traffic");
        applyStimulus(40);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
